npc_lsu: RTL and testbench

- Load/store unit between the execute stage and the DPI-backed data-memory model.
- Accepts one memory request at a time over a valid/ready handshake.
- Turns each request into a single-cycle, 8-byte-aligned read or write strobe on the memory port, with byte mask and data lane shifting.
- Returns the extracted, sign- or zero-extended load data over a valid/ready response handshake. Misaligned requests are flagged and never reach memory.

---
 rtl/npc_lsu_if.sv | 36 +++
 rtl/npc_lsu.sv | 148 ++++++++++++++
 tb/tb_npc_lsu.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/npc_lsu_if.sv
// Bundles the request, memory and response signals of the load/store unit.
// slave: the view taken by the LSU. master: the view of the surrounding pipeline and memory.
interface npc_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] mem_raddr;
    logic        mem_read;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_write;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_misalign;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        input  mem_rdata, resp_ready,
        output req_ready, mem_raddr, mem_read, mem_waddr, mem_wdata, mem_wmask,
        output mem_write, resp_valid, resp_rdata, resp_misalign
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        output mem_rdata, resp_ready,
        input  req_ready, mem_raddr, mem_read, mem_waddr, mem_wdata, mem_wmask,
        input  mem_write, resp_valid, resp_rdata, resp_misalign
    );
endinterface

// File: rtl/npc_lsu.sv
// Load/store unit: one request at a time, a single aligned 8-byte memory
// strobe per request, lane shifting for stores and extraction/extension for loads.
module npc_lsu #(
    parameter int unsigned MEM_DELAY = 0
) (
    input  logic      clk,
    input  logic      rst,
    npc_lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_wen;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [1:0]  cap_size;
    logic        cap_uns;

    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        logic [2:0] m;
        case (size)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return (off & m) != 3'b000;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [63:0] d, input logic [2:0] off);
        return d << {off, 3'b000};
    endfunction

    // Pull the addressed bytes down to bit 0 and sign- or zero-extend them.
    function automatic logic [63:0] extract(input logic [63:0] d, input logic [2:0] off,
                                            input logic [1:0] size, input logic uns);
        logic [63:0] s;
        logic [63:0] r;
        s = d >> {off, 3'b000};
        case (size)
            2'd0:    r = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            2'd1:    r = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            2'd2:    r = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Control FSM; every output is registered and set up one edge ahead of its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= 4'd0;
            cap_wen           <= 1'b0;
            cap_addr          <= 64'd0;
            cap_wdata         <= 64'd0;
            cap_size          <= 2'd0;
            cap_uns           <= 1'b0;
            bus.req_ready     <= 1'b1;
            bus.mem_raddr     <= 64'd0;
            bus.mem_waddr     <= 64'd0;
            bus.mem_read      <= 1'b0;
            bus.mem_write     <= 1'b0;
            bus.mem_wdata     <= 64'd0;
            bus.mem_wmask     <= 8'd0;
            bus.resp_valid    <= 1'b0;
            bus.resp_rdata    <= 64'd0;
            bus.resp_misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_wen       <= bus.req_wen;
                        cap_addr      <= bus.req_addr;
                        cap_wdata     <= bus.req_wdata;
                        cap_size      <= bus.req_size;
                        cap_uns       <= bus.req_unsigned;
                        bus.req_ready <= 1'b0;
                        if (misaligned(bus.req_addr[2:0], bus.req_size)) begin
                            state             <= RESP;
                            bus.resp_valid    <= 1'b1;
                            bus.resp_misalign <= 1'b1;
                            bus.resp_rdata    <= 64'd0;
                        end else begin
                            state         <= ACCESS;
                            cnt           <= 4'(MEM_DELAY);
                            bus.mem_raddr <= {bus.req_addr[63:3], 3'b000};
                            bus.mem_waddr <= {bus.req_addr[63:3], 3'b000};
                            // With no wait cycles the strobe belongs to the very next cycle.
                            if (MEM_DELAY == 0) begin
                                bus.mem_read  <= ~bus.req_wen;
                                bus.mem_write <= bus.req_wen;
                                bus.mem_wmask <= bus.req_wen ? lane_mask(bus.req_addr[2:0], bus.req_size) : 8'd0;
                                bus.mem_wdata <= bus.req_wen ? lane_data(bus.req_wdata, bus.req_addr[2:0]) : 64'd0;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        // Last wait cycle: arm the strobe for the cycle where cnt reads 0.
                        if (cnt == 4'd1) begin
                            bus.mem_read  <= ~cap_wen;
                            bus.mem_write <= cap_wen;
                            bus.mem_wmask <= cap_wen ? lane_mask(cap_addr[2:0], cap_size) : 8'd0;
                            bus.mem_wdata <= cap_wen ? lane_data(cap_wdata, cap_addr[2:0]) : 64'd0;
                        end
                    end else begin
                        state             <= RESP;
                        bus.mem_read      <= 1'b0;
                        bus.mem_write     <= 1'b0;
                        bus.mem_wmask     <= 8'd0;
                        bus.mem_wdata     <= 64'd0;
                        bus.mem_raddr     <= 64'd0;
                        bus.mem_waddr     <= 64'd0;
                        bus.resp_valid    <= 1'b1;
                        bus.resp_misalign <= 1'b0;
                        bus.resp_rdata    <= cap_wen ? 64'd0
                                           : extract(bus.mem_rdata, cap_addr[2:0], cap_size, cap_uns);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state             <= IDLE;
                        bus.resp_valid    <= 1'b0;
                        bus.resp_misalign <= 1'b0;
                        bus.resp_rdata    <= 64'd0;
                        bus.req_ready     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npc_lsu.sv
// Directed bench for npc_lsu: one instance with no memory delay, one with two wait cycles.
module tb_npc_lsu;
    logic clk;
    logic rst0;
    logic rst2;
    int   checks;
    int   failures;

    npc_lsu_if b0 ();
    npc_lsu_if b2 ();

    npc_lsu #(.MEM_DELAY(0)) dut0 (.clk(clk), .rst(rst0), .bus(b0));
    npc_lsu #(.MEM_DELAY(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request to dut0 and let one edge accept it; returns #1 after that edge.
    task automatic issue0(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input logic uns);
        b0.req_valid    = 1'b1;
        b0.req_wen      = wen;
        b0.req_addr     = addr;
        b0.req_wdata    = wdata;
        b0.req_size     = size;
        b0.req_unsigned = uns;
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
    endtask

    task automatic release0();
        b0.resp_ready = 1'b1;
        @(posedge clk); #1;
        b0.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (b0.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", b0.req_ready); end
        checks++; if (b0.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", b0.resp_valid); end
        checks++; if ({b0.mem_read, b0.mem_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {b0.mem_read, b0.mem_write}); end
        checks++; if (b0.mem_wmask !== 8'h00) begin failures++; $display("FAIL reset_wmask got=%h exp=00", b0.mem_wmask); end
        checks++; if (b0.resp_rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", b0.resp_rdata); end
        checks++; if (b2.req_ready !== 1'b1) begin failures++; $display("FAIL reset2_req_ready got=%b exp=1", b2.req_ready); end
    endtask

    task automatic test_byte_store();
        issue0(1'b1, 64'h8000_0003, 64'hAB, 2'd0, 1'b0);
        checks++; if (b0.mem_write !== 1'b1 || b0.mem_read !== 1'b0) begin failures++; $display("FAIL sb_strobe got w=%b r=%b exp w=1 r=0", b0.mem_write, b0.mem_read); end
        checks++; if (b0.mem_waddr !== 64'h8000_0000) begin failures++; $display("FAIL sb_waddr got=%h exp=80000000", b0.mem_waddr); end
        checks++; if (b0.mem_wmask !== 8'h08) begin failures++; $display("FAIL sb_wmask got=%h exp=08", b0.mem_wmask); end
        checks++; if (b0.mem_wdata !== 64'h0000_0000_AB00_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=00000000ab000000", b0.mem_wdata); end
        checks++; if (b0.req_ready !== 1'b0) begin failures++; $display("FAIL sb_req_ready got=%b exp=0", b0.req_ready); end
        @(posedge clk); #1;
        checks++; if (b0.mem_write !== 1'b0 || b0.mem_wmask !== 8'h00) begin failures++; $display("FAIL sb_strobe_once got w=%b m=%h exp w=0 m=00", b0.mem_write, b0.mem_wmask); end
        checks++; if (b0.resp_valid !== 1'b1 || b0.resp_rdata !== 64'd0 || b0.resp_misalign !== 1'b0) begin failures++; $display("FAIL sb_resp got v=%b d=%h m=%b exp v=1 d=0 m=0", b0.resp_valid, b0.resp_rdata, b0.resp_misalign); end
        release0();
        checks++; if (b0.resp_valid !== 1'b0 || b0.req_ready !== 1'b1) begin failures++; $display("FAIL sb_idle got v=%b rdy=%b exp v=0 rdy=1", b0.resp_valid, b0.req_ready); end
    endtask

    task automatic test_loads();
        b0.mem_rdata = 64'h8001_0000_0000_0000;
        issue0(1'b0, 64'h8000_0006, 64'd0, 2'd1, 1'b0);
        checks++; if (b0.mem_read !== 1'b1 || b0.mem_write !== 1'b0) begin failures++; $display("FAIL lh_strobe got r=%b w=%b exp r=1 w=0", b0.mem_read, b0.mem_write); end
        checks++; if (b0.mem_raddr !== 64'h8000_0000) begin failures++; $display("FAIL lh_raddr got=%h exp=80000000", b0.mem_raddr); end
        @(posedge clk); #1;
        checks++; if (b0.resp_valid !== 1'b1 || b0.resp_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin failures++; $display("FAIL lh_signed got v=%b d=%h exp v=1 d=ffffffffffff8001", b0.resp_valid, b0.resp_rdata); end
        release0();
        issue0(1'b0, 64'h8000_0006, 64'd0, 2'd1, 1'b1);
        @(posedge clk); #1;
        checks++; if (b0.resp_rdata !== 64'h0000_0000_0000_8001) begin failures++; $display("FAIL lhu got=%h exp=0000000000008001", b0.resp_rdata); end
        release0();
        b0.mem_rdata = 64'h89AB_CDEF_0000_0000;
        issue0(1'b0, 64'h8000_0014, 64'd0, 2'd2, 1'b0);
        checks++; if (b0.mem_raddr !== 64'h8000_0010) begin failures++; $display("FAIL lw_raddr got=%h exp=80000010", b0.mem_raddr); end
        @(posedge clk); #1;
        checks++; if (b0.resp_rdata !== 64'hFFFF_FFFF_89AB_CDEF) begin failures++; $display("FAIL lw_signed got=%h exp=ffffffff89abcdef", b0.resp_rdata); end
        release0();
        b0.mem_rdata = 64'hF011_2233_4455_6677;
        issue0(1'b0, 64'h8000_0007, 64'd0, 2'd0, 1'b1);
        @(posedge clk); #1;
        checks++; if (b0.resp_rdata !== 64'h0000_0000_0000_00F0) begin failures++; $display("FAIL lbu got=%h exp=00000000000000f0", b0.resp_rdata); end
        release0();
    endtask

    task automatic test_misalign();
        b0.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        issue0(1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0);
        checks++; if (b0.mem_read !== 1'b0 || b0.mem_write !== 1'b0) begin failures++; $display("FAIL mis_no_strobe got r=%b w=%b exp r=0 w=0", b0.mem_read, b0.mem_write); end
        checks++; if (b0.resp_valid !== 1'b1 || b0.resp_misalign !== 1'b1 || b0.resp_rdata !== 64'd0) begin failures++; $display("FAIL mis_resp got v=%b m=%b d=%h exp v=1 m=1 d=0", b0.resp_valid, b0.resp_misalign, b0.resp_rdata); end
        release0();
        checks++; if (b0.resp_misalign !== 1'b0 || b0.mem_read !== 1'b0) begin failures++; $display("FAIL mis_after got m=%b r=%b exp m=0 r=0", b0.resp_misalign, b0.mem_read); end
    endtask

    task automatic test_double_store_backpressure();
        issue0(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 2'd3, 1'b0);
        checks++; if (b0.mem_wmask !== 8'hFF) begin failures++; $display("FAIL sd_wmask got=%h exp=ff", b0.mem_wmask); end
        checks++; if (b0.mem_wdata !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL sd_wdata got=%h exp=1122334455667788", b0.mem_wdata); end
        checks++; if (b0.mem_waddr !== 64'h8000_0008) begin failures++; $display("FAIL sd_waddr got=%h exp=80000008", b0.mem_waddr); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (b0.resp_valid !== 1'b1 || b0.req_ready !== 1'b0 || b0.resp_rdata !== 64'd0 || b0.resp_misalign !== 1'b0) begin
                failures++; $display("FAIL sd_hold%0d got v=%b rdy=%b d=%h m=%b exp v=1 rdy=0 d=0 m=0", i, b0.resp_valid, b0.req_ready, b0.resp_rdata, b0.resp_misalign);
            end
        end
        release0();
        checks++; if (b0.resp_valid !== 1'b0 || b0.req_ready !== 1'b1) begin failures++; $display("FAIL sd_idle got v=%b rdy=%b exp v=0 rdy=1", b0.resp_valid, b0.req_ready); end
    endtask

    task automatic test_mem_delay();
        b2.mem_rdata    = 64'h0123_4567_89AB_CDEF;
        b2.req_valid    = 1'b1;
        b2.req_wen      = 1'b0;
        b2.req_addr     = 64'h8000_0000;
        b2.req_wdata    = 64'd0;
        b2.req_size     = 2'd3;
        b2.req_unsigned = 1'b0;
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            checks++; if (b2.mem_read !== 1'b0) begin failures++; $display("FAIL dly_wait%0d got r=%b exp=0", i, b2.mem_read); end
            @(posedge clk); #1;
        end
        checks++; if (b2.mem_read !== 1'b1 || b2.resp_valid !== 1'b0 || b2.mem_raddr !== 64'h8000_0000) begin failures++; $display("FAIL dly_strobe got r=%b v=%b a=%h exp r=1 v=0 a=80000000", b2.mem_read, b2.resp_valid, b2.mem_raddr); end
        @(posedge clk); #1;
        checks++; if (b2.mem_read !== 1'b0 || b2.resp_valid !== 1'b1 || b2.resp_rdata !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL dly_resp got r=%b v=%b d=%h exp r=0 v=1 d=0123456789abcdef", b2.mem_read, b2.resp_valid, b2.resp_rdata); end
        b2.resp_ready = 1'b1;
        @(posedge clk); #1;
        b2.resp_ready = 1'b0;
        checks++; if (b2.req_ready !== 1'b1) begin failures++; $display("FAIL dly_idle got rdy=%b exp=1", b2.req_ready); end
    endtask

    task automatic test_reset_abort();
        b2.req_valid = 1'b1;
        b2.req_wen   = 1'b1;
        b2.req_addr  = 64'h8000_0010;
        b2.req_wdata = 64'h55;
        b2.req_size  = 2'd0;
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
        rst2 = 1'b1;
        #1;
        checks++; if (b2.req_ready !== 1'b1 || b2.mem_write !== 1'b0) begin failures++; $display("FAIL abort_async got rdy=%b w=%b exp rdy=1 w=0", b2.req_ready, b2.mem_write); end
        @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        b2.resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (b2.mem_write !== 1'b0 || b2.resp_valid !== 1'b0 || b2.req_ready !== 1'b1 || b2.mem_wmask !== 8'h00) begin
                failures++; $display("FAIL abort_quiet%0d got w=%b v=%b rdy=%b m=%h exp w=0 v=0 rdy=1 m=00", i, b2.mem_write, b2.resp_valid, b2.req_ready, b2.mem_wmask);
            end
        end
        b2.resp_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst0 = 1'b1;
        rst2 = 1'b1;
        b0.req_valid = 1'b0; b0.req_wen = 1'b0; b0.req_addr = 64'd0; b0.req_wdata = 64'd0;
        b0.req_size = 2'd0; b0.req_unsigned = 1'b0; b0.mem_rdata = 64'd0; b0.resp_ready = 1'b0;
        b2.req_valid = 1'b0; b2.req_wen = 1'b0; b2.req_addr = 64'd0; b2.req_wdata = 64'd0;
        b2.req_size = 2'd0; b2.req_unsigned = 1'b0; b2.mem_rdata = 64'd0; b2.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst2 = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_byte_store();
        test_loads();
        test_misalign();
        test_double_store_backpressure();
        test_mem_delay();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
